// File: rtl/eth_mem_arbiter.sv
// Round-robin arbiter with bounded burst locking in front of the single framing-memory port.
// Define ETH_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module eth_mem_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_LOCK   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ-1:0]              lock_i,
  input  logic [N_REQ-1:0]              we_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [N_REQ*DATA_WIDTH/8-1:0] be_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [N_REQ-1:0]              gnt_o,
  output logic [N_REQ-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH/8-1:0]       mem_be_o,
  output logic [DATA_WIDTH-1:0]         mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]         mem_rdata_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  typedef struct packed {
    logic            vld;
    logic            rd;
    logic [ID_W-1:0] id;
  } tag_t;

  state_t           r_state;
  logic [ID_W-1:0]  r_owner;
  logic [CNT_W-1:0] r_cnt;
  tag_t             r_tag1;
  tag_t             r_tag2;

  logic [ID_W-1:0]  w_rr_start;
  logic [ID_W-1:0]  w_brk_start;
  logic [ID_W:0]    w_pick_rr;
  logic [ID_W:0]    w_pick_brk;
  logic             w_gnt_vld;
  logic [ID_W-1:0]  w_gnt_idx;
  logic             w_new_grant;
  logic             w_own_grant;
  logic             w_cnt_restart;

  function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] idx);
    return (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Returns {found, index} of the first requester at or after start (wrapping), optionally skipping one.
  function automatic logic [ID_W:0] pick(input logic [N_REQ-1:0] req,
                                         input logic [ID_W-1:0]  start,
                                         input logic             skip_en,
                                         input logic [ID_W-1:0]  skip);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] j;
    res = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = ID_W'((32'(start) + unsigned'(k)) % N_REQ);
      if (!res[ID_W] && req[j] && !(skip_en && (j == skip))) res = {1'b1, j};
    end
    return res;
  endfunction

`ifdef ETH_ARB_FIXED_PRIO_EN
  assign w_rr_start  = '0;
  assign w_brk_start = '0;
`else
  logic [ID_W-1:0] r_ptr;
  assign w_rr_start  = r_ptr;
  assign w_brk_start = next_idx(r_owner);
`endif

  assign w_pick_rr  = pick(req_i, w_rr_start, 1'b0, '0);
  assign w_pick_brk = pick(req_i, w_brk_start, 1'b1, r_owner);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    w_gnt_vld     = 1'b0;
    w_gnt_idx     = '0;
    w_new_grant   = 1'b0;
    w_own_grant   = 1'b0;
    w_cnt_restart = 1'b0;
    if (rst_i) begin
      w_gnt_vld = 1'b0;
    end else if (r_state == S_LOCKED && req_i[r_owner]) begin
      if (r_cnt < CNT_W'(MAX_LOCK)) begin
        w_gnt_vld   = 1'b1;
        w_gnt_idx   = r_owner;
        w_own_grant = 1'b1;
      end else if (w_pick_brk[ID_W]) begin
        w_gnt_vld   = 1'b1;
        w_gnt_idx   = w_pick_brk[ID_W-1:0];
        w_new_grant = 1'b1;
      end else begin
        w_gnt_vld     = 1'b1;
        w_gnt_idx     = r_owner;
        w_own_grant   = 1'b1;
        w_cnt_restart = 1'b1;
      end
    end else if (w_pick_rr[ID_W]) begin
      w_gnt_vld   = 1'b1;
      w_gnt_idx   = w_pick_rr[ID_W-1:0];
      w_new_grant = 1'b1;
    end
  end

  always_comb begin
    gnt_o = '0;
    if (w_gnt_vld) gnt_o[w_gnt_idx] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_cnt   <= '0;
`ifndef ETH_ARB_FIXED_PRIO_EN
      r_ptr   <= '0;
`endif
    end else if (w_new_grant) begin
`ifndef ETH_ARB_FIXED_PRIO_EN
      r_ptr <= next_idx(w_gnt_idx);
`endif
      if (lock_i[w_gnt_idx]) begin
        r_state <= S_LOCKED;
        r_owner <= w_gnt_idx;
        r_cnt   <= CNT_W'(1);
      end else begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end
    end else if (w_own_grant) begin
      // Locked grants never move the round-robin pointer.
      if (!lock_i[r_owner]) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else if (w_cnt_restart) begin
        r_cnt <= CNT_W'(1);
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end
  end

  // Downstream command register; address/data hold their last value while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      r_tag1      <= '0;
      r_tag2      <= '0;
    end else begin
      if (w_gnt_vld) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= we_i[w_gnt_idx];
        mem_addr_o  <= addr_i[w_gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        mem_be_o    <= be_i[w_gnt_idx*BE_W +: BE_W];
        mem_wdata_o <= wdata_i[w_gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        mem_req_o <= 1'b0;
        mem_we_o  <= 1'b0;
      end
      r_tag1 <= '{vld: w_gnt_vld, rd: ~we_i[w_gnt_idx], id: w_gnt_idx};
      r_tag2 <= r_tag1;
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (!rst_i && r_tag2.vld && r_tag2.rd) rvalid_o[r_tag2.id] = 1'b1;
  end

  assign rdata_o = (|rvalid_o) ? mem_rdata_i : '0;

endmodule
